// File: rtl/gcd_seq.sv
// -----------------------------------------------------------------------------
// gcd_seq -- sequencer that feeds one operand pair at a time to an external
// iterative gcd unit, waits for its done flag (or a cycle-budget timeout) and
// presents the captured result downstream on a valid/ready handshake.
//
// Parameters
//   TIMEOUT     maximum RUN cycles per operation (2..1023)
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   in_valid    operand pair valid (upstream)
//   in_ready    sequencer idle and able to accept a pair
//   in_a, in_b  operands
//   gcd_load    one-cycle load strobe to the gcd unit
//   gcd_a/b     operands held for the gcd unit
//   gcd_done    done flag from the gcd unit
//   gcd_y       result from the gcd unit
//   out_valid   result valid (downstream)
//   out_ready   downstream accepts the result
//   out_y       captured result (0 on timeout)
//   out_err     operation ended by timeout
//   out_cycles  RUN cycles consumed, terminating cycle included
// -----------------------------------------------------------------------------
module gcd_seq #(
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic       gcd_load,
  output logic [7:0] gcd_a,
  output logic [7:0] gcd_b,
  input  logic       gcd_done,
  input  logic [7:0] gcd_y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_y,
  output logic       out_err,
  output logic [9:0] out_cycles
);

  localparam logic [9:0] TIMEOUT_C = 10'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t     state_q, state_d;

  logic [7:0] gcd_a_q, gcd_a_d;
  logic [7:0] gcd_b_q, gcd_b_d;
  logic [9:0] cnt_q, cnt_d;
  logic [7:0] out_y_q, out_y_d;
  logic       out_err_q, out_err_d;
  logic [9:0] out_cycles_q, out_cycles_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       gcd_load_q, gcd_load_d;

  // Cycle number of the current RUN cycle (first RUN cycle is 1).
  logic [9:0] run_n;
  logic       run_timeout;

  assign run_n       = cnt_q + 10'd1;
  assign run_timeout = (run_n == TIMEOUT_C);

  // ---------------------------------------------------------------------------
  // State register and all other flops. Reset acts immediately so an
  // in-flight operation is abandoned without emitting a result.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gcd_a_q      <= 8'd0;
      gcd_b_q      <= 8'd0;
      cnt_q        <= 10'd0;
      out_y_q      <= 8'd0;
      out_err_q    <= 1'b0;
      out_cycles_q <= 10'd0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      gcd_load_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      gcd_a_q      <= gcd_a_d;
      gcd_b_q      <= gcd_b_d;
      cnt_q        <= cnt_d;
      out_y_q      <= out_y_d;
      out_err_q    <= out_err_d;
      out_cycles_q <= out_cycles_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      gcd_load_q   <= gcd_load_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. gcd_done is only looked at in RUN: in IDLE and LOAD the
  // unit may still be showing done from the previous operation.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_RUN;
      ST_RUN:  if (gcd_done || run_timeout) state_d = ST_HOLD;
      ST_HOLD: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic. Handshake flags and the load strobe are pure
  // decodes of the next state, registered so they line up with state_q.
  // ---------------------------------------------------------------------------
  always_comb begin
    gcd_a_d      = gcd_a_q;
    gcd_b_d      = gcd_b_q;
    cnt_d        = cnt_q;
    out_y_d      = out_y_q;
    out_err_d    = out_err_q;
    out_cycles_d = out_cycles_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          gcd_a_d = in_a;
          gcd_b_d = in_b;
        end
      end
      ST_LOAD: begin
        cnt_d = 10'd0;
      end
      ST_RUN: begin
        cnt_d = run_n;
        // done takes priority over a timeout landing on the same cycle
        if (gcd_done) begin
          out_y_d      = gcd_y;
          out_err_d    = 1'b0;
          out_cycles_d = run_n;
        end else if (run_timeout) begin
          out_y_d      = 8'd0;
          out_err_d    = 1'b1;
          out_cycles_d = TIMEOUT_C;
        end
      end
      ST_HOLD: begin
        // result registers hold until the downstream side takes them
      end
      default: begin
      end
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    gcd_load_d  = (state_d == ST_LOAD);
    out_valid_d = (state_d == ST_HOLD);
  end

  assign in_ready   = in_ready_q;
  assign gcd_load   = gcd_load_q;
  assign gcd_a      = gcd_a_q;
  assign gcd_b      = gcd_b_q;
  assign out_valid  = out_valid_q;
  assign out_y      = out_y_q;
  assign out_err    = out_err_q;
  assign out_cycles = out_cycles_q;

endmodule
